// File: rtl/apb_arbiter_if.sv
// Bundle of the two requester ports, the shared response and the APB
// master bus driven by apb_arbiter. The "master" modport is the arbiter's
// view. The "slave" modport is the view of everything around it:
// requesters, response consumers and the APB completer.
interface apb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  req0_valid;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [3:0]            req0_strb;
  logic                  req0_ack;
  logic                  rsp0_valid;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic [3:0]            req1_strb;
  logic                  req1_ack;
  logic                  rsp1_valid;

  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic                  timeout_evt;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    input  PRDATA, PREADY, PSLVERR,
    output req0_ack, rsp0_valid, req1_ack, rsp1_valid,
    output rsp_rdata, rsp_err, busy, timeout_evt,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    output PRDATA, PREADY, PSLVERR,
    input  req0_ack, rsp0_valid, req1_ack, rsp1_valid,
    input  rsp_rdata, rsp_err, busy, timeout_evt,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// One transfer at a time. A transfer ends when PREADY is seen, or it is
// aborted with an error after TIMEOUT ACCESS cycles without PREADY.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; requests sampled, winner acked and captured
// SETUP  | PSEL=1, PENABLE=0, lasts exactly one cycle
// ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_arbiter_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic                  last_gnt;   // requester granted most recently
  logic                  cur_id;     // requester owning the current transfer
  logic [CW-1:0]         wait_cnt;
  logic                  gnt0;
  logic                  gnt1;

  logic                  psel_q;
  logic                  penable_q;
  logic                  busy_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            strb_q;
  logic                  rsp0_q;
  logic                  rsp1_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  tevt_q;

  // Grant is decided combinationally in IDLE; on a tie the requester not
  // granted last wins. Held low during reset so no ack escapes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !PRESET) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // Sequencer: state, capture registers, wait counter and all registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur_id    <= 1'b0;
      wait_cnt  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= 4'b0000;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tevt_q    <= 1'b0;
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      tevt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            cur_id   <= gnt1;
            last_gnt <= gnt1;
            if (gnt1) begin
              write_q <= bus.req1_write;
              addr_q  <= bus.req1_addr;
              wdata_q <= bus.req1_wdata;
              strb_q  <= bus.req1_write ? bus.req1_strb : 4'b0000;
            end else begin
              write_q <= bus.req0_write;
              addr_q  <= bus.req0_addr;
              wdata_q <= bus.req0_wdata;
              strb_q  <= bus.req0_write ? bus.req0_strb : 4'b0000;
            end
            psel_q <= 1'b1;
            busy_q <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rdata_q   <= write_q ? '0 : bus.PRDATA;
            err_q     <= bus.PSLVERR;
            rsp0_q    <= !cur_id;
            rsp1_q    <= cur_id;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // completer never answered: abort with an error response
            rdata_q   <= '0;
            err_q     <= 1'b1;
            rsp0_q    <= !cur_id;
            rsp1_q    <= cur_id;
            tevt_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ack    = gnt0;
  assign bus.req1_ack    = gnt1;
  assign bus.rsp0_valid  = rsp0_q;
  assign bus.rsp1_valid  = rsp1_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_evt = tevt_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = write_q;
  assign bus.PADDR       = addr_q;
  assign bus.PWDATA      = wdata_q;
  assign bus.PSTRB       = strb_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Testbench for apb_arbiter. A transaction-level model, driven from the
// grant time and the age of the current transfer, predicts every output on
// every cycle. Directed scenarios add literal latency, data and grant-order
// expectations.
module tb_apb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;

  apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // completer behaviour knobs
  bit            hang      = 1'b0;
  int            wait_cfg  = 0;
  logic [DW-1:0] rdata_cfg = '0;
  bit            err_cfg   = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void bound_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: got no DUT event want one within bound (cycle %0d)", name, cyc);
  endfunction

  // ---------------- transaction-level model ----------------
  bit            m_act   = 1'b0;   // a transfer has been granted and not finished
  int            m_age   = 0;      // cycles since the grant cycle
  bit            m_id    = 1'b0;
  bit            m_last  = 1'b1;   // last granted id; 1 lets requester 0 win a tie
  logic          m_w     = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0]    m_strb  = '0;
  bit            m_rsp0  = 1'b0;
  bit            m_rsp1  = 1'b0;
  bit            m_tevt  = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_err   = 1'b0;

  function automatic void model_reset();
    m_act = 0; m_age = 0; m_id = 0; m_last = 1;
    m_w = 0; m_addr = '0; m_wdata = '0; m_strb = '0;
    m_rsp0 = 0; m_rsp1 = 0; m_tevt = 0; m_rdata = '0; m_err = 0;
  endfunction

  function automatic void model_respond(logic [DW-1:0] rd, bit er, bit tmo);
    m_rdata = rd;
    m_err   = er;
    m_tevt  = tmo;
    if (m_id) m_rsp1 = 1; else m_rsp0 = 1;
    m_act   = 0;
  endfunction

  // Compare every output on the falling edge, then advance the model to the next cycle.
  always @(negedge PCLK) begin
    logic       e_ack0, e_ack1, win;
    logic [7:0] e_ctrl, a_ctrl;
    a_ctrl = {bus.req0_ack, bus.req1_ack, bus.rsp0_valid, bus.rsp1_valid,
              bus.busy, bus.timeout_evt, bus.PSEL, bus.PENABLE};
    if (PRESET) begin
      model_reset();
      chk("reset_ctrl", a_ctrl, 0);
      chk("reset_paddr", bus.PADDR, 0);
      chk("reset_pwdata", bus.PWDATA, 0);
      chk("reset_pwrite_pstrb", {bus.PWRITE, bus.PSTRB}, 0);
      chk("reset_rsp", {bus.rsp_err, bus.rsp_rdata}, 0);
    end else begin
      e_ack0 = 0; e_ack1 = 0; win = 0;
      if (!m_act && (bus.req0_valid || bus.req1_valid)) begin
        if (bus.req0_valid && bus.req1_valid) win = ~m_last;
        else win = bus.req1_valid;
        e_ack0 = !win;
        e_ack1 = win;
      end
      e_ctrl = {e_ack0, e_ack1, m_rsp0, m_rsp1, m_act, m_tevt, m_act, m_act && (m_age >= 2)};
      chk("ctrl", a_ctrl, e_ctrl);
      chk("paddr", bus.PADDR, m_addr);
      chk("pwdata", bus.PWDATA, m_wdata);
      chk("pwrite_pstrb", {bus.PWRITE, bus.PSTRB}, {m_w, m_strb});
      chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("rsp_err", bus.rsp_err, m_err);

      m_rsp0 = 0; m_rsp1 = 0; m_tevt = 0;
      if (!m_act) begin
        if (e_ack0 || e_ack1) begin
          m_act = 1; m_age = 1; m_id = win; m_last = win;
          m_w     = win ? bus.req1_write : bus.req0_write;
          m_addr  = win ? bus.req1_addr  : bus.req0_addr;
          m_wdata = win ? bus.req1_wdata : bus.req0_wdata;
          m_strb  = m_w ? (win ? bus.req1_strb : bus.req0_strb) : 4'b0000;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (bus.PREADY) begin
        model_respond(m_w ? '0 : bus.PRDATA, bus.PSLVERR, 0);
      end else if (m_age - 1 == TO) begin
        model_respond('0, 1, 1);
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- APB completer ----------------
  initial begin
    int wcnt;
    bit prev;
    wcnt = 0;
    prev = 0;
    bus.PREADY  = 1'b1;
    bus.PRDATA  = 32'h5A5A_C3C3;
    bus.PSLVERR = 1'b1;
    forever begin
      @(posedge PCLK); #1;
      if (bus.PSEL && bus.PENABLE) begin
        wcnt = prev ? wcnt + 1 : 0;
        prev = 1;
        bus.PREADY  = !hang && (wcnt >= wait_cfg);
        bus.PRDATA  = rdata_cfg;
        bus.PSLVERR = err_cfg;
      end else begin
        // noise outside ACCESS must be ignored
        prev = 0;
        bus.PREADY  = 1'b1;
        bus.PRDATA  = 32'h5A5A_C3C3;
        bus.PSLVERR = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge PCLK); #1;
  endtask

  task automatic do_req(input bit id, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] s, output int lat);
    int ack_c, rsp_c;
    ack_c = -1; rsp_c = -1; lat = -1;
    if (id) begin
      bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_strb = s;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_strb = s;
      bus.req0_valid = 1'b1;
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if ((id ? bus.req1_ack : bus.req0_ack) === 1'b1) begin ack_c = cyc; break; end
    end
    step();
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    if (ack_c < 0) begin bound_fail("ack_wait"); return; end
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if ((id ? bus.rsp1_valid : bus.rsp0_valid) === 1'b1) begin rsp_c = cyc; break; end
    end
    if (rsp_c < 0) bound_fail("rsp_wait");
    else lat = rsp_c - ack_c;
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if (bus.busy === 1'b0) begin seen = 1; break; end
    end
    if (!seen) bound_fail(name);
  endtask

  initial begin
    int lat;
    int gl[$];
    bit seen;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_strb = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_strb = '0;
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    chk("reset_psel", bus.PSEL, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // zero-wait write from requester 0
    wait_cfg = 0; hang = 0; err_cfg = 0;
    step();
    do_req(0, 1, 32'h10, 32'hA5A5_0001, 4'hF, lat);
    chk("wr0_latency", lat, 3);
    chk("wr0_rsp_err", bus.rsp_err, 0);
    chk("wr0_pstrb", bus.PSTRB, 4'hF);
    chk("wr0_paddr", bus.PADDR, 32'h10);

    // read from requester 1 with three wait states; requester 0 pulses valid
    // while busy and drops it again, which must produce nothing
    wait_cfg = 3; rdata_cfg = 32'hDEAD_BEEF;
    step();
    fork
      do_req(1, 0, 32'h20, 32'h1234_5678, 4'hC, lat);
      begin
        repeat (2) @(posedge PCLK); #1;
        bus.req0_write = 0; bus.req0_addr = 32'h99; bus.req0_valid = 1;
        repeat (2) @(posedge PCLK); #1;
        bus.req0_valid = 0;
      end
    join
    chk("rd1_latency", lat, 6);
    chk("rd1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("rd1_pstrb", bus.PSTRB, 4'h0);
    chk("rd1_paddr", bus.PADDR, 32'h20);

    // both held valid: grants must alternate starting with requester 0
    wait_cfg = 0;
    step();
    bus.req0_write = 1; bus.req0_addr = 32'h100; bus.req0_wdata = 32'h1111_1111; bus.req0_strb = 4'h3;
    bus.req1_write = 1; bus.req1_addr = 32'h200; bus.req1_wdata = 32'h2222_2222; bus.req1_strb = 4'hC;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if (bus.req0_ack === 1'b1) gl.push_back(0);
      if (bus.req1_ack === 1'b1) gl.push_back(1);
      if (gl.size() >= 4) break;
    end
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    if (gl.size() == 4) begin
      chk("rr_grant0", gl[0], 0);
      chk("rr_grant1", gl[1], 1);
      chk("rr_grant2", gl[2], 0);
      chk("rr_grant3", gl[3], 1);
    end else begin
      bound_fail("rr_grants");
    end
    wait_idle("rr_idle");

    // slave error on one response, clean read right after
    err_cfg = 1;
    step();
    do_req(1, 1, 32'h40, 32'hCAFE_0000, 4'hF, lat);
    chk("err_latency", lat, 3);
    chk("err_flag", bus.rsp_err, 1);
    err_cfg = 0; rdata_cfg = 32'h0BAD_F00D;
    step();
    do_req(0, 0, 32'h44, 32'h0, 4'h0, lat);
    chk("clean_flag", bus.rsp_err, 0);
    chk("clean_rdata", bus.rsp_rdata, 32'h0BAD_F00D);

    // completer never ready: abort after TIMEOUT ACCESS cycles
    hang = 1;
    step();
    do_req(0, 0, 32'h30, 32'h0, 4'h5, lat);
    chk("tmo_latency", lat, TO + 2);
    chk("tmo_evt", bus.timeout_evt, 1);
    chk("tmo_err", bus.rsp_err, 1);
    chk("tmo_rdata", bus.rsp_rdata, 0);
    chk("tmo_psel", bus.PSEL, 0);
    hang = 0;

    // reset in the middle of ACCESS, then a tie must go to requester 0
    hang = 1;
    step();
    bus.req0_write = 0; bus.req0_addr = 32'h50; bus.req0_valid = 1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge PCLK);
      if (bus.req0_ack === 1'b1) begin seen = 1; break; end
    end
    step();
    bus.req0_valid = 0;
    if (!seen) bound_fail("rst_ack_wait");
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge PCLK);
      if (bus.PENABLE === 1'b1) begin seen = 1; break; end
    end
    if (!seen) bound_fail("rst_access_wait");
    step();
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    step();
    step();
    hang = 0;
    PRESET = 1'b0;
    bus.req0_write = 0; bus.req0_addr = 32'h60;
    bus.req1_write = 0; bus.req1_addr = 32'h64;
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge PCLK);
    chk("rst_tie_ack0", bus.req0_ack, 1);
    chk("rst_tie_ack1", bus.req1_ack, 0);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    wait_idle("rst_idle");
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ADDR_WIDTH, 32, address width of requesters and APB bus
  DATA_WIDTH, 32, data width of requesters and APB bus
  TIMEOUT, 16, max ACCESS cycles without PREADY before abort (>=2)
REQ-002 Ports, one per line (name, direction, width, meaning):
  PCLK  in  1  sole clock, all state changes on rising edge
  PRESET  in  1  asynchronous, active-high reset
  req0_valid  in  1  requester 0 transfer request
  req0_write  in  1  requester 0 direction, 1=write
  req0_addr  in  ADDR_WIDTH  requester 0 address
  req0_wdata  in  DATA_WIDTH  requester 0 write data
  req0_strb  in  4  requester 0 byte strobes
  req0_ack  out  1  requester 0 request captured
  rsp0_valid  out  1  requester 0 response pulse
  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb, req1_ack, rsp1_valid  same directions, widths and meanings as requester 0, for requester 1
  rsp_rdata  out  DATA_WIDTH  response read data, shared
  rsp_err  out  1  response error, shared
  busy  out  1  high in SETUP and ACCESS
  timeout_evt  out  1  one-cycle pulse on timeout abort
  PSEL  out  1  APB select
  PENABLE  out  1  APB enable
  PWRITE  out  1  APB direction
  PADDR  out  ADDR_WIDTH  APB address
  PWDATA  out  DATA_WIDTH  APB write data
  PSTRB  out  4  APB write strobes
  PRDATA  in  DATA_WIDTH  APB read data
  PREADY  in  1  APB ready
  PSLVERR  in  1  APB slave error

Function
REQ-003 FSM states IDLE, SETUP, ACCESS; IDLE is the only state in which requests are sampled.
REQ-004 IDLE with any reqN_valid: grant decided combinationally; reqN_ack of the winner high that cycle only; winner's write/addr/wdata/strb captured at that edge; next state SETUP.
REQ-005 Arbitration round-robin: single valid wins; both valid -> the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-006 Requester holds its signals stable until reqN_ack; valid dropped before ack means no transfer and no response.
REQ-007 SETUP: PSEL=1, PENABLE=0, exactly one cycle, next ACCESS.
REQ-008 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB held from capture registers, unchanged SETUP through end of ACCESS.
REQ-009 PSTRB driven 4'b0000 for reads, captured strobes for writes.
REQ-010 ACCESS with PREADY=1: at that edge rsp_rdata<=PRDATA (read) or 0 (write), rsp_err<=PSLVERR, rspN_valid of granted requester high for the following cycle only; next IDLE.
REQ-011 Wait counter cleared on entry to ACCESS, increments each ACCESS cycle with PREADY=0; PREADY=0 on the TIMEOUT-th ACCESS cycle -> abort: rsp_rdata<=0, rsp_err<=1, rspN_valid and timeout_evt pulse next cycle, next IDLE.
REQ-012 Zero-wait latency: ack cycle 0, SETUP cycle 1, ACCESS cycle 2, rspN_valid cycle 3; min 3 cycles per transfer, IDLE always one cycle between transfers.
REQ-013 In IDLE: PSEL=0, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB retain last values; rsp_rdata/rsp_err retain until next response.
REQ-014 PRDATA, PREADY, PSLVERR ignored outside ACCESS; only one rspN_valid high at a time.

Reset
REQ-015 PRESET high, asynchronously and at any state incl. mid-transfer: state IDLE, all outputs 0, wait counter 0, round-robin pointer to favour requester 0; aborted transfer yields no response pulse.

Verification
REQ-016 req0 write addr 0x10 data 0xA5A5_0001 strb 0xF, PREADY tied 1 -> ack c0, PSEL c1, PENABLE c2, rsp0_valid c3, rsp_err 0, PSTRB 0xF.
REQ-017 req1 read addr 0x20, PREADY after 3 wait cycles, PRDATA 0xDEAD_BEEF -> rsp1_valid with rsp_rdata 0xDEAD_BEEF, PSTRB 0, PADDR stable whole transfer.
REQ-018 req0 and req1 held valid continuously -> grants alternate 0,1,0,1; each ack once per transfer.
REQ-019 PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err 1, rsp_rdata 0, timeout_evt one pulse, PSEL low next cycle.
REQ-020 PSLVERR=1 with PREADY -> rsp_err 1 on that response only; next transfer error-free reports rsp_err 0.
REQ-021 PRESET asserted during ACCESS -> PSEL/PENABLE 0 immediately, no rspN_valid, next tie after release granted to requester 0.
